// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin EXU/LSU grant into a single register-file write port,
// plus a busy scoreboard that blocks WAW dispatch and flags pending source operands.
module wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_valid,
    input  logic [4:0]      exu_rd,
    input  logic [XLEN-1:0] exu_wd,
    output logic            exu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_wd,
    output logic            lsu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            wbu_valid,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] wd,
    output logic            reg_write_en
);

    logic            prio_reg, prio_next;
    logic            wbu_valid_reg;
    logic [4:0]      rd_reg, rd_next;
    logic [XLEN-1:0] wd_reg, wd_next;
    logic [31:1]     busy_bits_reg;
    logic [31:0]     busy;

    // prio=1 favours the LSU when both sources contend
    always_comb begin
        exu_ready = exu_valid & (~lsu_valid | ~prio_reg);
        lsu_ready = lsu_valid & (~exu_valid | prio_reg);
    end

    always_comb begin
        prio_next = prio_reg;
        rd_next   = rd_reg;
        wd_next   = wd_reg;
        if (exu_ready) begin
            prio_next = 1'b1;
            rd_next   = exu_rd;
            wd_next   = exu_wd;
        end else if (lsu_ready) begin
            prio_next = 1'b0;
            rd_next   = lsu_rd;
            wd_next   = lsu_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_reg      <= 1'b0;
            wbu_valid_reg <= 1'b0;
            rd_reg        <= '0;
            wd_reg        <= '0;
        end else begin
            prio_reg      <= prio_next;
            wbu_valid_reg <= exu_ready | lsu_ready;
            rd_reg        <= rd_next;
            wd_reg        <= wd_next;
        end
    end

    assign wbu_valid    = wbu_valid_reg;
    assign rd           = rd_reg;
    assign wd           = wd_reg;
    assign reg_write_en = wbu_valid_reg & (rd_reg != 5'd0);

    // x0 never becomes busy, so its bit is a constant zero
    assign busy = {busy_bits_reg, 1'b0};

    assign issue_ready = ~busy[issue_rd] | (issue_rd == 5'd0);
    assign rs1_busy    = busy[rs1] & (rs1 != 5'd0);
    assign rs2_busy    = busy[rs2] & (rs2 != 5'd0);

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit, clr_bit, busy_next;

            assign set_bit = issue_valid & issue_ready & (issue_rd == 5'(gi));
            assign clr_bit = wbu_valid_reg & (rd_reg == 5'(gi));
            // a new dispatch to the same register outranks the retiring write
            assign busy_next = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_bits_reg[gi]);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    busy_bits_reg[gi] <= 1'b0;
                else
                    busy_bits_reg[gi] <= busy_next;
            end
        end
    endgenerate

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 XLEN, 32, data width of write-back values.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 exu_valid  input  1  EXU result available.
REQ-006 exu_rd  input  5  EXU destination register.
REQ-007 exu_wd  input  XLEN  EXU result value.
REQ-008 exu_ready  output  1  EXU result accepted this cycle.
REQ-009 lsu_valid  input  1  LSU load result available.
REQ-010 lsu_rd  input  5  LSU destination register.
REQ-011 lsu_wd  input  XLEN  LSU load value.
REQ-012 lsu_ready  output  1  LSU result accepted this cycle.
REQ-013 issue_valid  input  1  decoder dispatching an instruction that writes issue_rd.
REQ-014 issue_rd  input  5  destination of dispatching instruction.
REQ-015 issue_ready  output  1  dispatch permitted (no WAW conflict).
REQ-016 rs1, rs2  input  5 each  source registers queried by decoder.
REQ-017 rs1_busy, rs2_busy  output  1 each  source has a pending uncommitted write.
REQ-018 wbu_valid  output  1  one-cycle register-file write strobe.
REQ-019 rd  output  5  register-file write address.
REQ-020 wd  output  XLEN  register-file write data.
REQ-021 reg_write_en  output  1  write enable; equals wbu_valid AND rd != 0.

Function
REQ-022 Handshake SHALL be valid/ready; a transfer occurs on a rising edge where valid and ready are both 1; ready is combinational from valid inputs and the priority pointer only.
REQ-023 At most one of exu_ready/lsu_ready SHALL be 1 per cycle; a ready is never asserted without its valid.
REQ-024 Only one requester valid: that requester is granted.
REQ-025 Both valid: the requester selected by 1-bit pointer prio (0=EXU, 1=LSU) is granted; after any grant, prio points to the non-granted source (round-robin).
REQ-026 No grant: prio unchanged.
REQ-027 Granted rd/wd SHALL be registered; wbu_valid=1 exactly the cycle after the grant (latency 1), otherwise 0; rd/wd hold last value when wbu_valid=0.
REQ-028 Scoreboard: 32-bit busy vector; bit 0 permanently 0.
REQ-029 issue_ready = NOT busy[issue_rd] OR issue_rd==0; evaluated on the registered busy vector, ignoring a same-cycle commit (conservative).
REQ-030 On issue_valid AND issue_ready AND issue_rd!=0: busy[issue_rd] set on next edge.
REQ-031 On wbu_valid AND rd!=0: busy[rd] cleared on that edge (commit).
REQ-032 Set and clear of the same bit on the same edge: set wins.
REQ-033 rsN_busy = busy[rsN] AND rsN!=0, from the registered vector; no same-cycle commit bypass.
REQ-034 Write-back to a non-busy rd SHALL still be performed; the busy bit stays 0.

Reset
REQ-035 While rst=0: busy=0, prio=0, wbu_valid=0, rd=0, wd=0, reg_write_en=0; exu_ready/lsu_ready follow REQ-024/025 with prio=0.
REQ-036 Assertion mid-transfer discards the registered write; nothing is committed after release until a new grant.

Verification
REQ-037 Reset release, exu_valid=1 exu_rd=5 exu_wd=0x1234 -> exu_ready=1 same cycle; next cycle wbu_valid=1 rd=5 wd=0x1234 reg_write_en=1.
REQ-038 exu_valid=lsu_valid=1 held 4 cycles after reset -> grants EXU,LSU,EXU,LSU; never both ready.
REQ-039 issue_valid=1 issue_rd=7, then rs1=7 -> rs1_busy=1 and issue_ready=0 for issue_rd=7 until cycle after the rd=7 write-back strobe.
REQ-040 Commit rd=7 and issue rd=7 on the same edge (issue accepted on a prior non-busy state via a different sequencing test) -> busy[7]=1 afterward.
REQ-041 lsu_valid=1 lsu_rd=0 lsu_wd=0xFFFF -> wbu_valid=1, reg_write_en=0; issue_rd=0 always issue_ready=1, rs1=0 never busy.
REQ-042 rst low during wbu_valid cycle with busy[3]=1 -> all outputs zero, busy cleared, prio=0 immediately (asynchronous).
